// File: rtl/mem_port_arbiter.sv
// Shares the single LC-3b memory port between the instruction-fetch (I) and data-access (D) sides.
// Optional macro ARB_DATA_PRIORITY_EN: D always wins simultaneous requests instead of round-robin.
`timescale 1ns/1ps
module mem_port_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_read,
  input  logic        i_write,
  input  logic [1:0]  i_byte_enable,
  input  logic [15:0] i_address,
  input  logic [15:0] i_wdata,
  output logic        i_resp,
  output logic [15:0] i_rdata,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [1:0]  d_byte_enable,
  input  logic [15:0] d_address,
  input  logic [15:0] d_wdata,
  output logic        d_resp,
  output logic [15:0] d_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_byte_enable,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  input  logic        mem_resp,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic {SIDE_I, SIDE_D} side_t;

  state_t      state;
  side_t       owner;
  side_t       last;
  logic [15:0] rdata;

  logic        i_req;
  logic        d_req;
  logic        grant_d;
  logic        sel_write;
  logic [1:0]  sel_be;
  logic [15:0] sel_addr;
  logic [15:0] sel_wdata;

  always_comb begin
    i_req = i_read | i_write;
    d_req = d_read | d_write;
`ifdef ARB_DATA_PRIORITY_EN
    grant_d = d_req;
`else
    grant_d = d_req & (~i_req | (last == SIDE_I));
`endif
    // Write dominates when a side raises read and write together.
    if (grant_d) begin
      sel_write = d_write;
      sel_be    = d_byte_enable;
      sel_addr  = d_address;
      sel_wdata = d_wdata;
    end else begin
      sel_write = i_write;
      sel_be    = i_byte_enable;
      sel_addr  = i_address;
      sel_wdata = i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      owner           <= SIDE_I;
      last            <= SIDE_D;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_byte_enable <= '0;
      mem_address     <= '0;
      mem_wdata       <= '0;
      i_resp          <= 1'b0;
      d_resp          <= 1'b0;
      rdata           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req | d_req) begin
            owner           <= grant_d ? SIDE_D : SIDE_I;
            mem_address     <= sel_addr;
            mem_wdata       <= sel_wdata;
            mem_write       <= sel_write;
            mem_read        <= ~sel_write;
            mem_byte_enable <= sel_write ? sel_be : 2'b11;
            state           <= BUSY;
          end
        end
        BUSY: begin
          if (mem_resp) begin
            rdata     <= mem_rdata;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            last      <= owner;
            i_resp    <= (owner == SIDE_I);
            d_resp    <= (owner == SIDE_D);
            state     <= DONE;
          end
        end
        DONE: begin
          i_resp <= 1'b0;
          d_resp <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign i_rdata = rdata;
  assign d_rdata = rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model of the grant/timing rules.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_read, i_write, d_read, d_write;
  logic [1:0]  i_byte_enable, d_byte_enable;
  logic [15:0] i_address, i_wdata, d_address, d_wdata;
  logic        i_resp, d_resp;
  logic [15:0] i_rdata, d_rdata;
  logic        mem_read, mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_address, mem_wdata;
  logic        mem_resp = 1'b0;
  logic [15:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_write(i_write), .i_byte_enable(i_byte_enable),
    .i_address(i_address), .i_wdata(i_wdata), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
    .d_address(d_address), .d_wdata(d_wdata), .d_resp(d_resp), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  typedef struct {
    bit          rd;
    bit          wr;
    logic [1:0]  be;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;

  req_t rq[2];   // index 0 = I side, 1 = D side

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Transaction-level model: edge numbers, not FSM states.
  int          edge_n = 0;
  int          free_at = 0;     // first edge at which a new request may be granted
  int          resp_edge = -10; // edge at which the current completion was sampled
  bit          busy = 1'b0;
  int          owner_m = 0;
  int          last_m = 1;
  bit          ex_wr;
  logic [1:0]  ex_be;
  logic [15:0] ex_addr, ex_wdata, ex_rdata;
  int          grant_q[$];
  int          grant_edge_q[$];
  int          op_cycles = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply();
    i_read = rq[0].rd; i_write = rq[0].wr; i_byte_enable = rq[0].be;
    i_address = rq[0].addr; i_wdata = rq[0].wdata;
    d_read = rq[1].rd; d_write = rq[1].wr; d_byte_enable = rq[1].be;
    d_address = rq[1].addr; d_wdata = rq[1].wdata;
  endtask

  task automatic clear_req(input int s);
    rq[s] = '{rd: 1'b0, wr: 1'b0, be: 2'b00, addr: 16'h0000, wdata: 16'h0000};
  endtask

  task automatic new_req(input int s);
    logic [1:0] op;
    op = 2'($urandom_range(3, 1));
    rq[s] = '{rd: op[0], wr: op[1], be: 2'($urandom), addr: 16'($urandom), wdata: 16'($urandom)};
  endtask

  // One clock: predict the effect of the coming edge, then check after it.
  task automatic step();
    int e;
    bit ri, rd;
    e  = edge_n;
    ri = rq[0].rd | rq[0].wr;
    rd = rq[1].rd | rq[1].wr;
    apply();
    if (!busy && e >= free_at && (ri || rd)) begin
      if (ri && rd) begin
`ifdef ARB_DATA_PRIORITY_EN
        owner_m = 1;
`else
        owner_m = 1 - last_m;
`endif
      end else begin
        owner_m = rd ? 1 : 0;
      end
      busy     = 1'b1;
      ex_wr    = rq[owner_m].wr;
      ex_be    = ex_wr ? rq[owner_m].be : 2'b11;
      ex_addr  = rq[owner_m].addr;
      ex_wdata = rq[owner_m].wdata;
      grant_q.push_back(owner_m);
      grant_edge_q.push_back(e);
    end else if (busy && mem_resp) begin
      busy      = 1'b0;
      last_m    = owner_m;
      resp_edge = e;
      ex_rdata  = mem_rdata;
      free_at   = e + 2;
    end
    @(posedge clk);
    @(negedge clk);
    edge_n++;
    check("mem_read", mem_read, busy && !ex_wr);
    check("mem_write", mem_write, busy && ex_wr);
    if (busy) begin
      op_cycles++;
      check("mem_address", mem_address, ex_addr);
      check("mem_wdata", mem_wdata, ex_wdata);
      check("mem_byte_enable", mem_byte_enable, ex_be);
    end
    check("i_resp", i_resp, resp_edge == e && owner_m == 0);
    check("d_resp", d_resp, resp_edge == e && owner_m == 1);
    if (resp_edge == e) check("rdata", owner_m == 1 ? d_rdata : i_rdata, ex_rdata);
  endtask

  // Asynchronous assert mid-cycle, synchronous release at the next negedge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_be", mem_byte_enable, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_i_resp", i_resp, 0);
    check("rst_d_resp", d_resp, 0);
    check("rst_rdata", i_rdata, 0);
    clear_req(0);
    clear_req(1);
    apply();
    mem_resp = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    busy      = 1'b0;
    last_m    = 1;
    resp_edge = -10;
    free_at   = edge_n;
    grant_q.delete();
    grant_edge_q.delete();
    op_cycles = 0;
  endtask

  initial begin
    clear_req(0);
    clear_req(1);
    apply();
    do_reset();

    // Single I read, memory answers after two busy cycles.
    rq[0] = '{rd: 1'b1, wr: 1'b0, be: 2'b00, addr: 16'h0040, wdata: 16'h0000};
    mem_resp = 1'b0;
    step();
    check("t1_be", mem_byte_enable, 2'b11);
    step();
    mem_resp = 1'b1; mem_rdata = 16'h1234;
    step();
    check("t1_i_resp", i_resp, 1);
    check("t1_i_rdata", i_rdata, 16'h1234);
    clear_req(0);
    mem_resp = 1'b0; mem_rdata = 16'h0000;
    step();
    check("t1_resp_width", i_resp, 0);
    check("t1_op_cycles", op_cycles, 2);

    // D write held stable until mem_resp.
    do_reset();
    rq[1] = '{rd: 1'b0, wr: 1'b1, be: 2'b01, addr: 16'h0100, wdata: 16'hBEEF};
    repeat (3) step();
    check("t2_wdata", mem_wdata, 16'hBEEF);
    check("t2_be", mem_byte_enable, 2'b01);
    mem_resp = 1'b1;
    step();
    check("t2_d_resp", d_resp, 1);
    check("t2_i_resp", i_resp, 0);
    clear_req(1);
    mem_resp = 1'b0;
    step();
    check("t2_op_cycles", op_cycles, 3);

    // Continuous contention with single-cycle memory.
    do_reset();
    rq[0] = '{rd: 1'b1, wr: 1'b0, be: 2'b00, addr: 16'h1000, wdata: 16'h0000};
    rq[1] = '{rd: 1'b0, wr: 1'b1, be: 2'b10, addr: 16'h2000, wdata: 16'h5A5A};
    mem_resp = 1'b1;
    repeat (14) step();
    check("t3_grant_count", grant_q.size() >= 4, 1);
    for (int k = 0; k < 4 && k < grant_q.size(); k++) begin
`ifdef ARB_DATA_PRIORITY_EN
      check("t3_grant_order", grant_q[k], 1);
`else
      check("t3_grant_order", grant_q[k], k % 2);
`endif
    end

    // Back-to-back I requests with D idle.
    do_reset();
    rq[0] = '{rd: 1'b1, wr: 1'b0, be: 2'b00, addr: 16'h0200, wdata: 16'h0000};
    mem_resp = 1'b1;
    repeat (8) step();
    check("t4_grants", grant_q.size() >= 2, 1);
    if (grant_q.size() >= 2) begin
      check("t4_owner", grant_q[1], 0);
      check("t4_gap", grant_edge_q[1] - grant_edge_q[0], 3);
    end

    // Reset during BUSY, then a stray mem_resp in IDLE.
    do_reset();
    rq[1] = '{rd: 1'b0, wr: 1'b1, be: 2'b11, addr: 16'h0300, wdata: 16'hCAFE};
    mem_resp = 1'b0;
    repeat (2) step();
    check("t5_busy_write", mem_write, 1);
    do_reset();
    mem_resp = 1'b1;
    repeat (3) step();
    check("t5_no_resp", i_resp | d_resp, 0);

    // Read and write together on one side.
    do_reset();
    rq[1] = '{rd: 1'b1, wr: 1'b1, be: 2'b10, addr: 16'h0400, wdata: 16'h1111};
    mem_resp = 1'b0;
    step();
    check("t6_mem_write", mem_write, 1);
    check("t6_mem_read", mem_read, 0);
    mem_resp = 1'b1;
    step();
    clear_req(1);
    mem_resp = 1'b0;
    step();

    // Random traffic from both sides with random memory latency.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int s = 0; s < 2; s++) begin
        bit done_s;
        done_s = (resp_edge == edge_n - 1) && (owner_m == s);
        if (done_s) begin
          if ($urandom_range(1, 0) == 1) new_req(s);
          else clear_req(s);
        end else if (!(rq[s].rd || rq[s].wr) && $urandom_range(2, 0) == 0) begin
          new_req(s);
        end
      end
      mem_resp  = ($urandom_range(2, 0) == 0);
      mem_rdata = 16'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
